mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register, writeback select and 32x32 general register file for the 5-stage CPU.
- Captures the MEM-stage instruction, ALU result and data-memory read word each cycle.
- Decodes the destination register and commits the writeback value into the register file.
- Provides two combinational read ports with write-through bypass to the decode stage.

Parameters:
- REG_COUNT, 32, number of architectural registers (index width fixed at 5 bits).
- OP_RTYPE, 6'b000000, opcode of register-register ALU ops; writes rd = ir[15:11].
- OP_LOAD, 6'b000001, opcode of load word; writes rt = ir[20:16] with the memory word.
- OP_STORE, 6'b000010, opcode of store word; no register write.
- OP_IMM, 6'b000101, opcode of immediate ALU ops; writes rt = ir[20:16] with the ALU result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold the MEM/WB register contents this cycle.
- flush  input  1  load a bubble (all-zero instruction) into MEM/WB this cycle.
- MEM_ir  input  32  instruction currently in MEM stage.
- MEM_alu_out  input  32  ALU result / address from EX/MEM.
- MEM_mem_out  input  32  data-memory read word for MEM_ir.
- rs_addr  input  5  read port A index.
- rt_addr  input  5  read port B index.
- rs_data  output  32  read port A data.
- rt_data  output  32  read port B data.
- WB_ir  output  32  registered instruction in WB stage.
- WB_we  output  1  register-file write enable for WB_ir (combinational from WB_ir).
- WB_waddr  output  5  destination register of WB_ir.
- WB_wdata  output  32  writeback value of WB_ir.

Behaviour:
- Control priority at each rising edge: reset > flush > stall > normal.
- reset: WB_ir, WB_alu and WB_mem registers all cleared to 0. All 32 register-file entries cleared to 0. No write is performed in that cycle.
- flush: WB_ir, WB_alu and WB_mem are set to 0 (bubble); the register-file write for the outgoing WB_ir still occurs.
- stall (without flush): WB registers hold their values; the write of the held instruction repeats (idempotent).
- normal: WB_ir <= MEM_ir, WB_alu <= MEM_alu_out, WB_mem <= MEM_mem_out.
- Decode of WB_ir[31:26]:
  - OP_RTYPE: waddr = ir[15:11], wdata = WB_alu.
  - OP_LOAD: waddr = ir[20:16], wdata = WB_mem.
  - OP_IMM: waddr = ir[20:16], wdata = WB_alu.
  - Any other opcode: WB_we = 0, WB_waddr = 0, WB_wdata = 0.
- WB_we = 1 only for the three writing opcodes and only when waddr != 0. Register 0 is never written and always reads 0.
- The all-zero instruction decodes as OP_RTYPE with rd = 0, so WB_we = 0 (true NOP).
- Register-file write happens at the rising edge when WB_we = 1, including the edge on which flush is asserted.
- Reads are combinational. If the read index is 0, data = 0. Otherwise, if WB_we = 1 and the read index equals WB_waddr, data = WB_wdata (write-through bypass). Otherwise data = the register-file entry.
- Latency: an instruction presented on MEM_ir at edge N is in WB after edge N. Its result is visible via bypass during cycle N+1 and resident in the register file after edge N+1.
- Reset outputs: WB_ir = 0, WB_we = 0, WB_waddr = 0, WB_wdata = 0, rs_data = rt_data = 0 for any index.
- Reset asserted mid-stream discards the instruction in WB without writing it.

Test Plan:
- Reset, then any rs_addr/rt_addr -> rs_data = rt_data = 0; WB_we = 0.
- Load MEM_ir = {OP_LOAD, 5'd0, 5'd3, 16'd0} with MEM_mem_out = 32'hDEADBEEF:
  - After edge 1: WB_waddr = 3, WB_we = 1, and rt_addr = 3 returns DEADBEEF via bypass.
  - After edge 2, with a NOP in MEM: rt_addr = 3 still reads DEADBEEF from the array.
- R-type MEM_ir = {OP_RTYPE, 5'd1, 5'd2, 5'd7, 11'd0} with MEM_alu_out = 32'h12345678 -> register 7 = 12345678 after two edges. A store {OP_STORE, ..., rt = 7} that follows leaves register 7 unchanged.
- Write to register 0: {OP_IMM, 5'd0, 5'd0, 16'h5} with ALU 5 -> WB_we = 0; rs_addr = 0 reads 0.
- Stall held 3 cycles with a new MEM_ir present -> WB_ir unchanged throughout. Flush and stall asserted together -> WB_ir = 0 next cycle, and the previous WB instruction is still committed.
- Load in WB with reset asserted on the same edge -> destination register reads 0 afterward; WB_ir = 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback select and 32x32 register file.
// Two combinational read ports bypass the value being written this cycle.
module mem_wb_stage #(
  parameter int         REG_COUNT = 32,
  parameter logic [5:0] OP_RTYPE  = 6'b000000,
  parameter logic [5:0] OP_LOAD   = 6'b000001,
  parameter logic [5:0] OP_STORE  = 6'b000010,
  parameter logic [5:0] OP_IMM    = 6'b000101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] MEM_ir,
  input  logic [31:0] MEM_alu_out,
  input  logic [31:0] MEM_mem_out,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] WB_ir,
  output logic        WB_we,
  output logic [4:0]  WB_waddr,
  output logic [31:0] WB_wdata
);

  logic [31:0] ir_q, ir_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mem_q, mem_d;
  logic [31:0] rf_q [REG_COUNT];

  logic [5:0]  opc;
  logic        is_r, is_ld, is_imm;
  logic        wr_op;
  logic [4:0]  dst;
  logic [31:0] val;

  assign opc    = ir_q[31:26];
  assign is_r   = (opc == OP_RTYPE);
  assign is_ld  = (opc == OP_LOAD);
  assign is_imm = (opc == OP_IMM);

  always_comb begin
    wr_op = 1'b0;
    dst   = 5'd0;
    val   = 32'd0;
    unique case (1'b1)
      is_r: begin
        wr_op = 1'b1;
        dst   = ir_q[15:11];
        val   = alu_q;
      end
      is_ld: begin
        wr_op = 1'b1;
        dst   = ir_q[20:16];
        val   = mem_q;
      end
      is_imm: begin
        wr_op = 1'b1;
        dst   = ir_q[20:16];
        val   = alu_q;
      end
      default: begin
        wr_op = 1'b0;
      end
    endcase
  end

  assign WB_ir    = ir_q;
  assign WB_we    = wr_op && (dst != 5'd0);
  assign WB_waddr = dst;
  assign WB_wdata = val;

  // Flush beats stall: a bubble replaces whatever was held.
  always_comb begin
    ir_d  = ir_q;
    alu_d = alu_q;
    mem_d = mem_q;
    if (flush) begin
      ir_d  = 32'd0;
      alu_d = 32'd0;
      mem_d = 32'd0;
    end else if (!stall) begin
      ir_d  = MEM_ir;
      alu_d = MEM_alu_out;
      mem_d = MEM_mem_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= 32'd0;
      alu_q <= 32'd0;
      mem_q <= 32'd0;
      for (int i = 0; i < REG_COUNT; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      ir_q  <= ir_d;
      alu_q <= alu_d;
      mem_q <= mem_d;
      if (WB_we) begin
        rf_q[WB_waddr] <= WB_wdata;
      end
    end
  end

  always_comb begin
    rs_data = rf_q[rs_addr];
    if (rs_addr == 5'd0) begin
      rs_data = 32'd0;
    end else if (WB_we && (rs_addr == WB_waddr)) begin
      rs_data = WB_wdata;
    end
  end

  always_comb begin
    rt_data = rf_q[rt_addr];
    if (rt_addr == 5'd0) begin
      rt_data = 32'd0;
    end else if (WB_we && (rt_addr == WB_waddr)) begin
      rt_data = WB_wdata;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised and directed bench for mem_wb_stage.
// A value-level model tracks the WB slot and architectural registers.
module tb_mem_wb_stage;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b000001;
  localparam logic [5:0] OP_STORE = 6'b000010;
  localparam logic [5:0] OP_IMM   = 6'b000101;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] MEM_ir, MEM_alu_out, MEM_mem_out;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, WB_ir, WB_wdata;
  logic        WB_we;
  logic [4:0]  WB_waddr;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: the instruction sitting in WB and the register values
  logic [31:0] m_ir, m_alu, m_mem;
  logic [31:0] m_rf [32];

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .MEM_ir(MEM_ir), .MEM_alu_out(MEM_alu_out), .MEM_mem_out(MEM_mem_out),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .WB_ir(WB_ir), .WB_we(WB_we), .WB_waddr(WB_waddr), .WB_wdata(WB_wdata)
  );

  function automatic logic writes(input logic [31:0] ir);
    return ir[31:26] == OP_RTYPE || ir[31:26] == OP_LOAD ||
           ir[31:26] == OP_IMM;
  endfunction

  function automatic logic [4:0] dest(input logic [31:0] ir);
    if (ir[31:26] == OP_RTYPE) return ir[15:11];
    if (writes(ir)) return ir[20:16];
    return 5'd0;
  endfunction

  function automatic logic [31:0] result(input logic [31:0] ir,
      input logic [31:0] alu, input logic [31:0] mem);
    if (ir[31:26] == OP_LOAD) return mem;
    if (writes(ir)) return alu;
    return 32'd0;
  endfunction

  function automatic logic exp_we();
    return writes(m_ir) && dest(m_ir) != 5'd0;
  endfunction

  // Architectural view: latest value of a register, pending write included
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (exp_we() && dest(m_ir) == a) return result(m_ir, m_alu, m_mem);
    return m_rf[a];
  endfunction

  task automatic step(input logic r, input logic s, input logic f,
      input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] mem);
    @(negedge clk);
    reset = r; stall = s; flush = f;
    MEM_ir = ir; MEM_alu_out = alu; MEM_mem_out = mem;
    @(posedge clk);
    if (r) begin
      m_ir = 0; m_alu = 0; m_mem = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (exp_we()) m_rf[dest(m_ir)] = result(m_ir, m_alu, m_mem);
      if (f) begin
        m_ir = 0; m_alu = 0; m_mem = 0;
      end else if (!s) begin
        m_ir = ir; m_alu = alu; m_mem = mem;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h2);
    step(1, 0, 0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i += 5) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i); #1;
      n_tests++;
      if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_read idx=%0d rs=%h rt=%h want 0", i, rs_data, rt_data);
      end
    end
    n_tests++;
    if (WB_we !== 1'b0 || WB_ir !== 32'd0 || WB_waddr !== 5'd0 ||
        WB_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_wb we=%b ir=%h wa=%0d wd=%h want all 0",
               WB_we, WB_ir, WB_waddr, WB_wdata);
    end
  endtask

  task automatic test_load();
    step(0, 0, 0, {OP_LOAD, 5'd0, 5'd3, 16'd0}, 32'h40, 32'hDEADBEEF);
    rt_addr = 5'd3; #1;
    n_tests++;
    if (WB_waddr !== 5'd3 || WB_we !== 1'b1 || rt_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_bypass wa=%0d we=%b rt=%h want 3 1 deadbeef",
               WB_waddr, WB_we, rt_data);
    end
    step(0, 0, 0, 32'd0, 32'h0, 32'h0);
    rt_addr = 5'd3; #1;
    n_tests++;
    if (WB_we !== 1'b0 || rt_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_array we=%b rt=%h want 0 deadbeef", WB_we, rt_data);
    end
  endtask

  task automatic test_rtype_store();
    step(0, 0, 0, {OP_RTYPE, 5'd1, 5'd2, 5'd7, 11'd0}, 32'h12345678, 32'h0);
    step(0, 0, 0, {OP_STORE, 5'd1, 5'd7, 16'h10}, 32'hFFFF0000, 32'h99);
    n_tests++;
    if (WB_we !== 1'b0 || WB_waddr !== 5'd0 || WB_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL store_decode we=%b wa=%0d wd=%h want 0 0 0",
               WB_we, WB_waddr, WB_wdata);
    end
    step(0, 0, 0, 32'd0, 32'h0, 32'h0);
    rs_addr = 5'd7; #1;
    n_tests++;
    if (rs_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rtype_r7 got=%h want 12345678", rs_data);
    end
  endtask

  task automatic test_r0();
    step(0, 0, 0, {OP_IMM, 5'd0, 5'd0, 16'h5}, 32'h5, 32'h0);
    rs_addr = 5'd0; #1;
    n_tests++;
    if (WB_we !== 1'b0 || rs_data !== 32'd0) begin
      n_fail++;
      $display("FAIL r0_write we=%b rs=%h want 0 0", WB_we, rs_data);
    end
    step(0, 0, 0, 32'd0, 32'h0, 32'h0);
    rs_addr = 5'd0; #1;
    n_tests++;
    if (rs_data !== 32'd0) begin
      n_fail++;
      $display("FAIL r0_after got=%h want 0", rs_data);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] held;
    held = {OP_IMM, 5'd1, 5'd9, 16'h1};
    step(0, 0, 0, held, 32'hAAAA5555, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 0, {OP_IMM, 5'd2, 5'd10, 16'h2}, 32'hBBBB, 32'h0);
      n_tests++;
      if (WB_ir !== held || WB_waddr !== 5'd9) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d ir=%h want %h", c, WB_ir, held);
      end
    end
    step(0, 1, 1, {OP_IMM, 5'd2, 5'd10, 16'h2}, 32'hBBBB, 32'h0);
    rs_addr = 5'd9; rt_addr = 5'd10; #1;
    n_tests++;
    if (WB_ir !== 32'd0 || rs_data !== 32'hAAAA5555 || rt_data !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_stall ir=%h r9=%h r10=%h want 0 aaaa5555 0",
               WB_ir, rs_data, rt_data);
    end
  endtask

  task automatic test_reset_midstream();
    step(0, 0, 0, {OP_LOAD, 5'd0, 5'd4, 16'd0}, 32'h0, 32'h55AA55AA);
    step(1, 0, 0, 32'd0, 32'h0, 32'h0);
    rs_addr = 5'd4; rt_addr = 5'd9; #1;
    n_tests++;
    if (WB_ir !== 32'd0 || rs_data !== 32'd0 || rt_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid ir=%h r4=%h r9=%h want 0 0 0",
               WB_ir, rs_data, rt_data);
    end
  endtask

  task automatic test_random();
    logic [5:0]  opc;
    logic [31:0] ir;
    logic        r, s, f;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 4))
        0: opc = OP_RTYPE;
        1: opc = OP_LOAD;
        2: opc = OP_STORE;
        3: opc = OP_IMM;
        default: opc = 6'($urandom);
      endcase
      ir = {opc, 26'($urandom)};
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 12);
      f = ($urandom_range(0, 99) < 8);
      step(r, s, f, ir, $urandom, $urandom);
      rs_addr = 5'($urandom); rt_addr = 5'($urandom);
      if ($urandom_range(0, 2) == 0) rs_addr = dest(m_ir);
      #1;
      n_tests++;
      if (WB_ir !== m_ir || WB_we !== exp_we() ||
          WB_waddr !== dest(m_ir) ||
          WB_wdata !== result(m_ir, m_alu, m_mem)) begin
        n_fail++;
        $display("FAIL rand_wb c=%0d ir=%h we=%b wa=%0d wd=%h want %h %b %0d %h",
                 c, WB_ir, WB_we, WB_waddr, WB_wdata, m_ir, exp_we(),
                 dest(m_ir), result(m_ir, m_alu, m_mem));
      end
      n_tests++;
      if (rs_data !== exp_rd(rs_addr) || rt_data !== exp_rd(rt_addr)) begin
        n_fail++;
        $display("FAIL rand_rd c=%0d rs[%0d]=%h rt[%0d]=%h want %h %h",
                 c, rs_addr, rs_data, rt_addr, rt_data,
                 exp_rd(rs_addr), exp_rd(rt_addr));
      end
    end
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); #1;
      n_tests++;
      if (rs_data !== exp_rd(5'(i))) begin
        n_fail++;
        $display("FAIL rand_final r%0d=%h want %h", i, rs_data, exp_rd(5'(i)));
      end
    end
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    MEM_ir = 0; MEM_alu_out = 0; MEM_mem_out = 0;
    rs_addr = 0; rt_addr = 0;
    m_ir = 0; m_alu = 0; m_mem = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    test_reset();
    test_load();
    test_rtype_store();
    test_r0();
    test_stall_flush();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
